// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle restoring divide/remainder sequencer driving a shared add/sub ALU
module alu_div_seq #(
    parameter int         XLEN    = 32,
    parameter logic [2:0] CTL_ADD = 3'b000,
    parameter logic [2:0] CTL_SUB = 3'b001
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_signed,
    input  logic            req_rem,
    input  logic [XLEN-1:0] req_dividend,
    input  logic [XLEN-1:0] req_divisor,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [2:0]      alu_ctl,
    output logic [XLEN-1:0] alu_src_a,
    output logic [XLEN-1:0] alu_src_b,
    input  logic [XLEN-1:0] alu_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SPECIAL, NEG_A, NEG_B, ITER, FIX, DONE} state_t;

    state_t          state, nxt;
    logic            sgn, rem, take, fneg, spec;
    logic [XLEN-1:0] a, b, q, r, d, res, rp, fv;
    logic [CW-1:0]   cnt;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign resp_data  = res;

    always_comb begin
        rp   = {r[XLEN-2:0], q[XLEN-1]};
        // r[XLEN-1] is the bit shifted out of R', so R' really exceeds D
        take = r[XLEN-1] | (rp >= d);
        fv   = rem ? r : q;
        fneg = sgn & (rem ? a[XLEN-1] : a[XLEN-1] ^ b[XLEN-1]);
        spec = (req_divisor == '0) | (req_signed & (req_dividend == MIN) & (req_divisor == '1));
        nxt       = state;
        alu_ctl   = CTL_ADD;
        alu_src_a = '0;
        alu_src_b = '0;
        case (state)
            IDLE:    nxt = req_valid ? (spec ? SPECIAL : NEG_A) : IDLE;
            SPECIAL: nxt = DONE;
            NEG_A: begin
                alu_ctl   = CTL_SUB;
                alu_src_b = a;
                nxt       = NEG_B;
            end
            NEG_B: begin
                alu_ctl   = CTL_SUB;
                alu_src_b = b;
                nxt       = ITER;
            end
            ITER: begin
                alu_ctl   = CTL_SUB;
                alu_src_a = rp;
                alu_src_b = d;
                nxt       = (cnt == '0) ? FIX : ITER;
            end
            FIX: begin
                alu_ctl   = fneg ? CTL_SUB : CTL_ADD;
                alu_src_b = fneg ? fv : '0;
                nxt       = DONE;
            end
            DONE:    nxt = resp_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sgn <= 1'b0;
            rem <= 1'b0;
            a   <= '0;
            b   <= '0;
            q   <= '0;
            r   <= '0;
            d   <= '0;
            res <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    sgn <= req_signed;
                    rem <= req_rem;
                    a   <= req_dividend;
                    b   <= req_divisor;
                end
                SPECIAL: res <= (b == '0) ? (rem ? a : '1) : (rem ? '0 : MIN);
                NEG_A: begin
                    q <= (sgn & a[XLEN-1]) ? alu_result : a;
                    r <= '0;
                end
                NEG_B: begin
                    d   <= (sgn & b[XLEN-1]) ? alu_result : b;
                    cnt <= CW'(XLEN-1);
                end
                ITER: begin
                    r   <= take ? alu_result : rp;
                    q   <= {q[XLEN-2:0], take};
                    cnt <= cnt - 1'b1;
                end
                FIX:     res <= fneg ? alu_result : fv;
                default: ;
            endcase
        end
    end
endmodule
